counter_nb: RTL and testbench
=============================

Name: counter_nb

Overview:
- Parametrised successor to the free-running 3-bit counter.
- N-bit modulo counter with:
  - count enable
  - up/down direction
  - synchronous parallel load
  - clock prescaler
  - terminal-count and wrap outputs
- Used as the general-purpose counter/timebase for lab designs (LED sequencers, display multiplexing, timers).
- With the default parameters and en=1, up=1, it behaves as a 3-bit 0..7 wrapping counter.

Parameters:
- WIDTH, 3, counter width in bits; legal range 1..32.
- MAX, 7, terminal count; q counts 0..MAX; legal range 1..2^WIDTH-1.
- DIV, 1, prescale factor; q steps once per DIV enabled clocks; legal range 1..2^16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  count enable; gates both the prescaler and the counter.
- up  input  1  direction; 1 counts up, 0 counts down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: (up && q==MAX) || (!up && q==0).
- wrap  output  1  registered one-cycle pulse marking a wrap-around.

Behaviour:
- Reset is synchronous and active-low. When rst_n==0 at a rising clk edge:
  - q=0, wrap=0, prescaler count=0.
  - tc follows q and up, so after reset it reads 1 if up==0.
- Priority per edge: reset > load > step > hold.
- Load (load==1):
  - q <= min(load_val, MAX).
  - Prescaler count cleared to 0; wrap <= 0.
  - en is ignored in a load cycle.
- Prescaler:
  - Internal counter p counts 0..DIV-1, advancing only when en==1.
  - tick = en && (p==DIV-1).
  - On tick, p <= 0.
  - When en==0, p holds.
  - For DIV==1, tick == en and p is optimised away.
- Step (tick==1, no load):
  - Up: q==MAX → q<=0 and wrap<=1; otherwise q<=q+1.
  - Down: q==0 → q<=MAX and wrap<=1; otherwise q<=q-1.
  - Arithmetic is WIDTH-bit unsigned; no intermediate overflow is possible because MAX ≤ 2^WIDTH-1.
- wrap is high exactly one cycle: the cycle after the edge that wrapped. It is 0 on every other edge, including hold cycles.
- Direction change takes effect on the next tick. The prescaler phase is not disturbed.
- q outside 0..MAX is unreachable: load clamps and reset clears.
- Reset mid-count, including mid-prescale, discards all state immediately at that edge.
- Load in the same cycle as a tick: load wins, and no wrap pulse is produced.

Optional Feature:
- Macro: COUNTER_NB_SAT_EN.
- Defined: saturating mode.
  - Up at q==MAX holds MAX; down at q==0 holds 0.
  - wrap is tied to 0.
  - tc is unchanged.
- Undefined: modulo wrap behaviour as above.
- Port list is identical in both builds.

Decomposition:
- Shared package counter_pkg holds:
  - function clog2 (used to size the prescaler as clog2(DIV)).
  - Direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
- One sub-module, prescaler, with ports clk, rst_n, en, clr, tick, parameterised by DIV.
  - Reusable by other timebase blocks.
  - counter_nb drives clr from load.

Test Plan:
- Default params, rst_n=0 for 2 clks then 1, en=1, up=1 for 20 clks → q = 0,1,..,7,0,1..; wrap high the cycle q returns to 0; tc high when q==7.
- WIDTH=4, MAX=9, up=0 from reset → q = 9,8,..,0,9; wrap pulses on the 0→9 transition; tc high at q==0.
- WIDTH=4, MAX=9, DIV=3, en=1, up=1 → q increments every 3rd clock; en=0 for 5 clks mid-prescale → q and phase hold, resuming with the remaining count.
- load=1, load_val=12 with MAX=9 → q=9 next cycle, no wrap; load together with tick at q==9 → q=load value, wrap=0.
- rst_n=0 asserted at q=5 mid-prescale → q=0, wrap=0 next edge; first tick after release occurs DIV enabled clocks later.
- COUNTER_NB_SAT_EN defined, MAX=7, up=1 for 12 clks → q sticks at 7, wrap never asserts; then up=0 → counts down to 0 and sticks.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared definitions for the counter_nb timebase family.
//            - clog2() sizes prescaler phase registers.
//            - DIR_UP / DIR_DOWN encode the count direction input.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2; returns 0 for values <= 1. Bounded loop keeps it elaborable.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_nb_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : prescaler
// Purpose  : Enable-gated clock prescaler. Emits a one-cycle tick on every
//            DIV-th enabled clock. Reusable by other timebase blocks.
// Ports    : clk   - rising-edge clock
//            rst_n - synchronous active-low reset (phase -> 0)
//            en    - advances the phase; phase holds when low
//            clr   - synchronous phase clear
//            tick  - en && (phase == DIV-1), combinational
// Params   : DIV   - prescale factor, 1..65536
// Revision : 1.0 - initial release
// ============================================================================
module prescaler
  import counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (DIV == 1) begin : g_div1
    // No phase to keep: every enabled clock is a tick.
    logic w_unused;
    assign w_unused = ^{clk, rst_n, clr};
    assign tick     = en;
  end else begin : g_divn
    localparam int            c_PW   = clog2(DIV);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DIV - 1);

    logic [c_PW-1:0] r_phase_q;
    logic [c_PW-1:0] w_phase_d;
    logic            w_last;

    assign w_last = (r_phase_q == c_LAST);
    assign tick   = en && w_last;

    always_comb begin
      w_phase_d = r_phase_q;
      if (clr) begin
        w_phase_d = '0;
      end else if (en) begin
        w_phase_d = w_last ? '0 : r_phase_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_phase_q <= '0;
      end else begin
        r_phase_q <= w_phase_d;
      end
    end
  end

endmodule : prescaler
`default_nettype wire

// File: rtl/counter_nb.sv
`default_nettype none
// ============================================================================
// Module   : counter_nb
// Purpose  : Parametrised modulo-(MAX+1) up/down counter with count enable,
//            synchronous load (clamped to MAX), prescaler, terminal-count and
//            wrap outputs. Priority per edge: reset > load > step > hold.
// Ports    : clk      - rising-edge clock
//            rst_n    - synchronous active-low reset
//            en       - count enable (gates prescaler and counter)
//            up       - direction, 1 = up, 0 = down
//            load     - synchronous load strobe
//            load_val - value to load, clamped to MAX
//            q        - registered count
//            tc       - combinational terminal count
//            wrap     - registered one-cycle wrap-around pulse
// Params   : WIDTH (1..32), MAX (1..2^WIDTH-1), DIV (1..65536)
// Options  : COUNTER_NB_SAT_EN - saturate at the ends instead of wrapping;
//            wrap is then tied low.
// Revision : 1.0 - initial release
// ============================================================================
module counter_nb
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MAX   = 7,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

  logic             w_tick;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] r_cnt_q;

  // Load clears the phase so the first step after a load is a full DIV away.
  prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .tick  (w_tick)
  );

  assign w_at_max       = (r_cnt_q == c_MAX);
  assign w_at_zero      = (r_cnt_q == '0);
  assign w_load_clamped = (load_val > c_MAX) ? c_MAX : load_val;

  assign q  = r_cnt_q;
  assign tc = ((up == DIR_UP) && w_at_max) || ((up == DIR_DOWN) && w_at_zero);

`ifdef COUNTER_NB_SAT_EN
  assign wrap = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_q <= '0;
    end else if (load) begin
      r_cnt_q <= w_load_clamped;
    end else if (w_tick) begin
      if (up == DIR_UP) begin
        if (!w_at_max) r_cnt_q <= r_cnt_q + 1'b1;
      end else begin
        if (!w_at_zero) r_cnt_q <= r_cnt_q - 1'b1;
      end
    end
  end
`else
  logic r_wrap_q;

  assign wrap = r_wrap_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_q  <= '0;
      r_wrap_q <= 1'b0;
    end else if (load) begin
      r_cnt_q  <= w_load_clamped;
      r_wrap_q <= 1'b0;
    end else if (w_tick) begin
      if (up == DIR_UP) begin
        r_cnt_q  <= w_at_max ? '0 : r_cnt_q + 1'b1;
        r_wrap_q <= w_at_max;
      end else begin
        r_cnt_q  <= w_at_zero ? c_MAX : r_cnt_q - 1'b1;
        r_wrap_q <= w_at_zero;
      end
    end else begin
      // Pulse lasts exactly one cycle, including across hold cycles.
      r_wrap_q <= 1'b0;
    end
  end
`endif

endmodule : counter_nb
`default_nettype wire

// File: tb/tb_counter_nb.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_nb
// Purpose  : Self-checking bench for counter_nb. Three instances share the
//            stimulus: default (W3/M7/D1), W4/M9/D3 and W4/M9/D1. Each is
//            compared every cycle against an arithmetic reference model.
//            Honours COUNTER_NB_SAT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_nb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;

  logic [2:0] q0;
  logic [3:0] q1, q2;
  logic       tc0, tc1, tc2;
  logic       wrap0, wrap1, wrap2;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  int maxv[3]  = '{7, 9, 9};
  int divv[3]  = '{1, 3, 1};
  int wmask[3] = '{7, 15, 15};
  int mq[3];
  int mp[3];
  int mw[3];

  always #5 clk = ~clk;

  counter_nb u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val[2:0]), .q(q0), .tc(tc0), .wrap(wrap0)
  );

  counter_nb #(.WIDTH(4), .MAX(9), .DIV(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q1), .tc(tc1), .wrap(wrap1)
  );

  counter_nb #(.WIDTH(4), .MAX(9), .DIV(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q2), .tc(tc2), .wrap(wrap2)
  );

  // Advance model k by one clock edge using the current inputs.
  task automatic model_edge(input int k);
    int lv;
    bit tick;
    lv = int'(load_val) & wmask[k];
    if (!rst_n) begin
      mq[k] = 0; mp[k] = 0; mw[k] = 0;
    end else if (load) begin
      mq[k] = (lv > maxv[k]) ? maxv[k] : lv;
      mp[k] = 0; mw[k] = 0;
    end else begin
      tick = 1'b0;
      if (en) begin
        mp[k] = mp[k] + 1;
        if (mp[k] == divv[k]) begin
          mp[k] = 0;
          tick  = 1'b1;
        end
      end
      mw[k] = 0;
      if (tick) begin
`ifdef COUNTER_NB_SAT_EN
        if (up) mq[k] = (mq[k] < maxv[k]) ? mq[k] + 1 : maxv[k];
        else    mq[k] = (mq[k] > 0) ? mq[k] - 1 : 0;
`else
        if (up) begin
          mw[k] = (mq[k] == maxv[k]) ? 1 : 0;
          mq[k] = (mq[k] + 1) % (maxv[k] + 1);
        end else begin
          mw[k] = (mq[k] == 0) ? 1 : 0;
          mq[k] = (mq[k] + maxv[k]) % (maxv[k] + 1);
        end
`endif
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int tc_of(input int k);
    return ((up && mq[k] == maxv[k]) || (!up && mq[k] == 0)) ? 1 : 0;
  endfunction

  task automatic check_all();
    check("q0",    int'(q0),    mq[0]);
    check("wrap0", int'(wrap0), mw[0]);
    check("tc0",   int'(tc0),   tc_of(0));
    check("q1",    int'(q1),    mq[1]);
    check("wrap1", int'(wrap1), mw[1]);
    check("tc1",   int'(tc1),   tc_of(1));
    check("q2",    int'(q2),    mq[2]);
    check("wrap2", int'(wrap2), mw[2]);
    check("tc2",   int'(tc2),   tc_of(2));
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; mp[k] = 0; mw[k] = 0;
    end
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0;

    // Reset for two clocks, with absolute checks of the reset state.
    run(2);
    check("rst_q0_abs", int'(q0), 0);
    check("rst_wrap1_abs", int'(wrap1), 0);
    rst_n = 1'b1;

    // Count up: default instance wraps 7 -> 0 every 8 clocks.
    run(9);
    check("up_q2_abs", int'(q2), 9);
    check("up_tc2_abs", int'(tc2), 1);

    // Load together with a tick at q==9 on the DIV=1 instance: load wins.
    load = 1'b1; load_val = 4'd3;
    step();
    check("ld_tick_wrap2_abs", int'(wrap2), 0);
    load = 1'b0;
    run(11);

    // Down from reset: 0 -> MAX wrap.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    up = 1'b0;
    run(25);

    // Enable pause mid-prescale: everything holds.
    up = 1'b1;
    run(4);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(6);

    // Load above MAX clamps; no wrap.
    load = 1'b1; load_val = 4'd12;
    step();
    check("ld_clamp_q1_abs", int'(q1), 9);
    load = 1'b0;
    run(7);

    // Reset mid-count and mid-prescale, then resume.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    run(8);

    // Direction change mid-prescale.
    up = 1'b0; run(5); up = 1'b1; run(5);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) up = ~up;
      load     = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom_range(0, 15));
      rst_n    = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_counter_nb
`default_nettype wire
